// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial multi-channel adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One channel of the serial adder: carry flop plus full-adder slice.
module serial_fa_cell
  import serial_addsub_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic first,
  input  logic mode_eff,
  input  logic a,
  input  logic b,
  output logic sum_c,
  output logic cnext_c,
  output logic ovf_c
);

  logic carry_q;
  logic bb;
  logic cin;

  // Subtraction is a + ~b + 1: invert b and seed the carry with 1 on bit 0.
  always_comb begin
    bb      = b ^ (mode_eff == MODE_SUB);
    cin     = first ? mode_eff : carry_q;
    sum_c   = a ^ bb ^ cin;
    cnext_c = (a & bb) | (a & cin) | (bb & cin);
    ovf_c   = cin ^ cnext_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= cnext_c;
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first add/subtract on NCH channels sharing one framing handshake.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned NCH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_first,
  input  logic           mode,
  input  logic [NCH-1:0] a,
  input  logic [NCH-1:0] b,
  output logic [NCH-1:0] stream,
  output logic           out_valid,
  output logic           out_last,
  output logic [NCH-1:0] carry_out,
  output logic [NCH-1:0] ovf,
  output logic           busy,
  output logic           err
);

  localparam int unsigned CW = clog2(WORD_W);
  localparam logic [CW-1:0] CNT_MSB = CW'(WORD_W - 1);

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          mode_q, mode_n;

  logic           first_beat;
  logic           process;
  logic           is_msb;
  logic           mode_eff;
  logic [NCH-1:0] sum_c;
  logic [NCH-1:0] cnext_c;
  logic [NCH-1:0] ovf_c;

  logic [NCH-1:0] stream_n;
  logic           out_valid_n;
  logic           out_last_n;
  logic [NCH-1:0] carry_out_n;
  logic [NCH-1:0] ovf_n;
  logic           busy_n;
  logic           err_n;

  // Beat qualification shared by the FSM and the datapath.
  always_comb begin
    first_beat = in_valid & in_first;
    process    = in_valid & (in_first | (state_q == RUN));
    is_msb     = (state_q == RUN) & ~in_first & (cnt_q == CNT_MSB);
    mode_eff   = first_beat ? mode : mode_q;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    serial_fa_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (process),
      .first    (first_beat),
      .mode_eff (mode_eff),
      .a        (a[ch]),
      .b        (b[ch]),
      .sum_c    (sum_c[ch]),
      .cnext_c  (cnext_c[ch]),
      .ovf_c    (ovf_c[ch])
    );
  end

  // State, counter, latched mode and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= MODE_ADD;
      stream    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      carry_out <= '0;
      ovf       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      mode_q    <= mode_n;
      stream    <= stream_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      carry_out <= carry_out_n;
      ovf       <= ovf_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

  // A first beat always (re)starts a word, even mid-word; that is the abort path.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    mode_n  = mode_q;
    if (first_beat) begin
      state_n = RUN;
      cnt_n   = CW'(1);
      mode_n  = mode;
    end else if (in_valid && (state_q == RUN)) begin
      if (is_msb) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    stream_n    = '0;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    carry_out_n = '0;
    ovf_n       = '0;
    err_n       = 1'b0;
    busy_n      = (state_n == RUN);
    if (process) begin
      out_valid_n = 1'b1;
      stream_n    = sum_c;
      if (is_msb) begin
        out_last_n  = 1'b1;
        carry_out_n = cnext_c;
        ovf_n       = ovf_c;
      end
    end
    if (first_beat && (state_q == RUN)) err_n = 1'b1;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: arithmetic word model compared every cycle, plus literal result checks.
module tb_serial_addsub;

  localparam int unsigned W = 8;
  localparam int unsigned N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_first;
  logic         mode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] stream;
  logic         out_valid;
  logic         out_last;
  logic [N-1:0] carry_out;
  logic [N-1:0] ovf;
  logic         busy;
  logic         err;

  serial_addsub #(.WORD_W(W), .NCH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .stream    (stream),
    .out_valid (out_valid),
    .out_last  (out_last),
    .carry_out (carry_out),
    .ovf       (ovf),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    logic [1:0] c;
    logic [1:0] o;
  } res_t;
  res_t res_q[$];

  int last_cnt = 0;
  int err_cnt  = 0;
  int ov_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: rebuild operands as integers and read result bits arithmetically.
  logic [N-1:0] e_stream, e_carry, e_ovf;
  logic         e_valid, e_last, e_err, e_busy;
  bit           active;
  int           idx;
  logic         mm;
  int           opa[N], opb[N];
  bit           chk_en = 0;

  always @(posedge clk) begin
    e_stream = '0; e_carry = '0; e_ovf = '0;
    e_valid = 0; e_last = 0; e_err = 0;
    if (rst) begin
      active = 0; idx = 0; mm = 0;
    end else if (in_valid && (in_first || active)) begin
      if (in_first) begin
        e_err = active;
        active = 1; idx = 0; mm = mode;
        for (int c = 0; c < N; c++) begin opa[c] = 0; opb[c] = 0; end
      end
      e_valid = 1;
      for (int c = 0; c < N; c++) begin
        int r, sa, sb, sr;
        opa[c] = opa[c] | (int'(a[c]) << idx);
        opb[c] = opb[c] | (int'(b[c]) << idx);
        r = mm ? (opa[c] - opb[c]) : (opa[c] + opb[c]);
        e_stream[c] = r[idx];
        if (idx == W - 1) begin
          sa = (opa[c] >> (W - 1)) & 1;
          sb = (opb[c] >> (W - 1)) & 1;
          sr = (r >> (W - 1)) & 1;
          e_carry[c] = mm ? (opa[c] >= opb[c]) : r[W];
          e_ovf[c]   = mm ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        end
      end
      if (idx == W - 1) begin
        e_last = 1; active = 0; idx = 0;
      end else begin
        idx++;
      end
    end
    e_busy = active;
  end

  logic [7:0] sh[N];

  // Compare DUT against the model every cycle and collect finished words.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stream", 32'(stream), 32'(e_stream));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_last", 32'(out_last), 32'(e_last));
      chk("carry_out", 32'(carry_out), 32'(e_carry));
      chk("ovf", 32'(ovf), 32'(e_ovf));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("err", 32'(err), 32'(e_err));
      if (err === 1'b1) err_cnt++;
      if (out_valid === 1'b1) begin
        ov_cnt++;
        for (int c = 0; c < N; c++) sh[c] = {stream[c], sh[c][7:1]};
        if (out_last === 1'b1) begin
          res_t r;
          r.w0 = sh[0]; r.w1 = sh[1]; r.c = carry_out; r.o = ovf;
          res_q.push_back(r);
          last_cnt++;
        end
      end
    end
  end

  task automatic beat(input logic v, input logic f, input logic m,
                      input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    in_valid = v; in_first = f; mode = m; a = av; b = bv;
  endtask

  // Send bits [0, nbits) of a word; optional stall of stall_len cycles before bit stall_at.
  task automatic send_word(input logic m, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input int nbits, input int stall_at, input int stall_len);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) repeat (stall_len) beat(1'b0, 1'b1, ~m, 2'b11, 2'b11);
      beat(1'b1, (i == 0), (i == 0) ? m : ~m, {a1[i], a0[i]}, {b1[i], b0[i]});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_res(input string name, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [1:0] c, input logic [1:0] o);
    res_t r;
    chk({name, "_present"}, 32'(res_q.size() != 0), 32'(1));
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      chk({name, "_w0"}, 32'(r.w0), 32'(w0));
      chk({name, "_w1"}, 32'(r.w1), 32'(w1));
      chk({name, "_carry"}, 32'(r.c), 32'(c));
      chk({name, "_ovf"}, 32'(r.o), 32'(o));
    end
  endtask

  initial begin
    int ov_before, last_before;
    rst = 1'b1; in_valid = 0; in_first = 0; mode = 0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset_outputs", 32'({stream, out_valid, out_last, carry_out, ovf, busy, err}), 32'(0));
    rst = 1'b0;
    idle(1);

    // Plain adds, then a back-to-back subtract word with no bubble.
    send_word(1'b0, 8'h05, 8'h03, 8'h7F, 8'h01, 8, -1, 0);
    idle(1);
    send_word(1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 8, -1, 0);
    send_word(1'b1, 8'h80, 8'h01, 8'h00, 8'h01, 8, -1, 0);
    idle(2);
    check_res("add_basic", 8'h08, 8'h80, 2'b00, 2'b10);
    check_res("add_wrap", 8'h00, 8'h00, 2'b01, 2'b00);
    check_res("sub", 8'h7F, 8'hFF, 2'b01, 2'b01);

    // Stall for three cycles after bit 3.
    ov_before = ov_cnt;
    send_word(1'b0, 8'h05, 8'h03, 8'h01, 8'h02, 8, 4, 3);
    idle(2);
    chk("stall_valid_beats", 32'(ov_cnt - ov_before), 32'(8));
    check_res("stall", 8'h08, 8'h03, 2'b00, 2'b00);

    // IDLE beats without in_first are ignored.
    ov_before = ov_cnt;
    repeat (3) beat(1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
    idle(2);
    chk("idle_no_output", 32'(ov_cnt - ov_before), 32'(0));

    // Abort at bit 4, new word starts on that beat.
    last_before = last_cnt;
    send_word(1'b0, 8'hAA, 8'h55, 8'h11, 8'h22, 4, -1, 0);
    send_word(1'b0, 8'h10, 8'h20, 8'h7F, 8'h7F, 8, -1, 0);
    idle(2);
    chk("abort_err_pulses", 32'(err_cnt), 32'(1));
    chk("abort_last_count", 32'(last_cnt - last_before), 32'(1));
    check_res("after_abort", 8'h30, 8'hFE, 2'b00, 2'b10);

    // Synchronous reset in the middle of a word.
    send_word(1'b1, 8'hF0, 8'h0F, 8'h33, 8'h44, 5, -1, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_first = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    send_word(1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8, -1, 0);
    idle(2);
    check_res("after_rst", 8'h02, 8'h00, 2'b00, 2'b00);
    chk("err_total", 32'(err_cnt), 32'(1));
    chk("no_extra_words", 32'(res_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
